multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Moore main-control FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified memory port, IR/PC/ALUOut registers.
- Decodes opcode from the IR and steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives the mux selects, the register/memory write strobes and the 2-bit ALUOp consumed by the ALU decoder: 00 add, 01 sub, 10 funct-decoded.
- Owns the memory request/ready handshake and a per-access timeout.

Parameters:
TIMEOUT, 255, max cycles a memory access may wait for mem_ready; 0 disables the timeout.
TIMEOUT_W, 8, width of the wait counter; must hold TIMEOUT.

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset; asynchronous, active-low
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
zero  in  1  ALU zero flag, current cycle
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
mem_write  out  1  request is a store
adr_src  out  1  memory address: 0 PC, 1 ALUOut
ir_write  out  1  load IR (and OldPC) from read data
pc_write  out  1  load PC from Result
reg_write  out  1  write register file
result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
alu_op  out  2  to ALU decoder
instr_done  out  1  one-cycle pulse when an instruction retires
trap  out  1  sticky: illegal instruction or memory timeout
trap_cause  out  1  0 illegal, 1 timeout; valid while trap=1

Behaviour:
- Async reset → state IDLE, wait counter 0, trap 0, trap_cause 0. In IDLE all outputs are 0. IDLE → FETCH unconditionally.
- Every output not listed for a state below is 0.
- FETCH: mem_req=1, adr_src=0, A=00, B=10, alu_op=00, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - mem_ready=1 → DECODE; otherwise stay in FETCH.
- DECODE: A=01, B=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 with funct3 000 or 001 → BRANCH
  - 1101111 → JAL
  - anything else → TRAP with cause 0
- MEMADR: A=10, B=01, alu_op=00. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. mem_ready=1 → MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1 → FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. mem_ready=1 → FETCH, with instr_done=1 in that cycle.
- EXEC_R: A=10, B=00, alu_op=10 → ALUWB.
- EXEC_I: A=10, B=01, alu_op=10 → ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1 → FETCH.
- BRANCH: A=10, B=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0] (beq when funct3[0]=0, bne when 1).
  - instr_done=1 → FETCH.
- JAL: A=01, B=10, alu_op=00, result_src=00, pc_write=1 → ALUWB (writes PC+4 to rd).
- Wait counter:
  - Cleared on entry to FETCH/MEMREAD/MEMWRITE and whenever mem_ready=1.
  - Increments each cycle spent in those states with mem_ready=0.
  - If TIMEOUT≠0 and counter reaches TIMEOUT with mem_ready still 0 → TRAP with cause 1. The access is abandoned and no strobe fires.
- TRAP: trap=1 and all other outputs 0. Held until rst_n=0; no other exit.
- Simultaneous events: mem_ready=1 in the same cycle the counter hits TIMEOUT → the access completes and no trap is taken.
- rst_n falling mid-instruction: outputs drop to IDLE values immediately (asynchronously); the partial instruction is discarded.
- CPI: R/I/JAL 4 cycles, load 5, store 4, branch 3, each with zero memory wait.

Test Plan:
- Reset release, opcode=0110011, mem_ready=1 → IDLE, FETCH(ir_write=1, pc_write=1), DECODE, EXEC_R(alu_op=10), ALUWB(reg_write=1, instr_done=1); 5 cycles from IDLE.
- lw (0000011) with mem_ready held 0 for 3 cycles in MEMREAD → mem_req=1 and adr_src=1 held; MEMWB reg_write=1 and result_src=01 exactly one cycle after ready.
- beq with zero=1 → pc_write=1 in BRANCH; beq with zero=0 → pc_write=0; bne (funct3=001) with zero=0 → pc_write=1.
- jal → JAL cycle with pc_write=1 and A=01/B=10, then ALUWB with reg_write=1.
- Illegal opcode 1110011 → TRAP, trap=1, trap_cause=0, no strobes; persists until rst_n=0.
- Timeout with TIMEOUT=4, mem_ready stuck 0 in FETCH → trap=1, trap_cause=1 after 4 wait cycles. Repeat with mem_ready=1 on cycle 4 → no trap.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the shared multicycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback and guards memory waits with a timeout.
module multicycle_controller #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       trap,
  output logic       trap_cause
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  localparam bit          TO_EN       = (TIMEOUT != 0);
  localparam int unsigned TO_LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TO_LAST_INT[TIMEOUT_W-1:0];

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 cause_q, cause_d;
  logic                 in_wait, timed_out;

  assign in_wait   = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  // A ready arriving on the last allowed cycle wins over the timeout.
  assign timed_out = TO_EN && in_wait && !mem_ready && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = '0;
    if (in_wait && !mem_ready)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXEC_R;
          7'b0010011:             state_d = EXEC_I;
          7'b1101111:             state_d = JAL;
          7'b1100011: begin
            if (funct3[2:1] == 2'b00) state_d = BRANCH;
            else begin
              state_d = TRAP;
              cause_d = 1'b0;
            end
          end
          default: begin
            state_d = TRAP;
            cause_d = 1'b0;
          end
        endcase
      end
      MEMADR:   state_d = opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXEC_R:   state_d = ALUWB;
      EXEC_I:   state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = IDLE;
    endcase

    if (timed_out) begin
      state_d = TRAP;
      cause_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Outputs decode from the state register; ir/pc strobes also qualify on ready/zero.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    trap       = 1'b0;
    trap_cause = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        result_src = 2'b10;
        alu_src_b  = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = zero ^ funct3[0];
        instr_done = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle
// and compares the packed control word against hand-derived values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       instr_done, trap, trap_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
  );

  // {req, wr, adr, irw, pcw, rw, rs[1:0], a[1:0], b[1:0], op[1:0], done, trap, cause}
  logic [16:0] ctrl;
  assign ctrl = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, instr_done, trap, trap_cause};

  function automatic logic [16:0] cv(input logic req, wr, adr, irw, pcw, rw,
                                     input logic [1:0] rs, a, b, op,
                                     input logic done, tr, tc);
    return {req, wr, adr, irw, pcw, rw, rs, a, b, op, done, tr, tc};
  endfunction

  function automatic logic [16:0] e_fetch(input logic r);
    return cv(1, 0, 0, r, r, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
  endfunction
  function automatic logic [16:0] e_decode();  return cv(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0,0); endfunction
  function automatic logic [16:0] e_memadr();  return cv(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0); endfunction
  function automatic logic [16:0] e_memread(); return cv(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0); endfunction
  function automatic logic [16:0] e_memwb();   return cv(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 1,0,0); endfunction
  function automatic logic [16:0] e_memwrite(input logic r);
    return cv(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, r, 0, 0);
  endfunction
  function automatic logic [16:0] e_exec_r();  return cv(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0,0); endfunction
  function automatic logic [16:0] e_exec_i();  return cv(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10, 0,0,0); endfunction
  function automatic logic [16:0] e_aluwb();   return cv(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0,0); endfunction
  function automatic logic [16:0] e_branch(input logic p);
    return cv(0, 0, 0, 0, p, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0, 0);
  endfunction
  function automatic logic [16:0] e_jal();     return cv(0,0,0,0,1,0, 2'b00,2'b01,2'b10,2'b00, 0,0,0); endfunction
  function automatic logic [16:0] e_trap(input logic c);
    return cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, c);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Inputs are already applied; check this cycle's outputs, then advance one edge.
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    check_eq(tag, {15'b0, ctrl}, {15'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("reset_async_idle", {15'b0, ctrl}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    cyc("idle", '0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    check_eq("reset_held", {15'b0, ctrl}, 32'h0);
    rst_n = 1'b1;

    // R-type, zero wait
    opcode = 7'b0110011; mem_ready = 1'b1;
    cyc("r_idle", '0);
    cyc("r_fetch", e_fetch(1));
    cyc("r_decode", e_decode());
    cyc("r_exec", e_exec_r());
    cyc("r_aluwb", e_aluwb());

    // lw with 3 wait cycles in MEMREAD
    opcode = 7'b0000011;
    cyc("lw_fetch", e_fetch(1));
    cyc("lw_decode", e_decode());
    mem_ready = 1'b0;
    cyc("lw_memadr", e_memadr());
    for (int i = 0; i < 3; i++) cyc("lw_memread_wait", e_memread());
    mem_ready = 1'b1;
    cyc("lw_memread_rdy", e_memread());
    cyc("lw_memwb", e_memwb());

    // sw
    opcode = 7'b0100011;
    cyc("sw_fetch", e_fetch(1));
    cyc("sw_decode", e_decode());
    cyc("sw_memadr", e_memadr());
    cyc("sw_memwrite", e_memwrite(1));

    // addi
    opcode = 7'b0010011;
    cyc("addi_fetch", e_fetch(1));
    cyc("addi_decode", e_decode());
    cyc("addi_exec", e_exec_i());
    cyc("addi_aluwb", e_aluwb());

    // branches: {funct3, zero, expected pc_write}
    opcode = 7'b1100011;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] f3_tab [4];
      logic       z_tab [4];
      logic       p_tab [4];
      f3_tab = '{3'b000, 3'b000, 3'b001, 3'b001};
      z_tab  = '{1'b1, 1'b0, 1'b0, 1'b1};
      p_tab  = '{1'b1, 1'b0, 1'b1, 1'b0};
      funct3 = f3_tab[i];
      zero   = z_tab[i];
      cyc("br_fetch", e_fetch(1));
      cyc("br_decode", e_decode());
      cyc("br_branch", e_branch(p_tab[i]));
    end
    funct3 = 3'b000; zero = 1'b0;

    // jal
    opcode = 7'b1101111;
    cyc("jal_fetch", e_fetch(1));
    cyc("jal_decode", e_decode());
    cyc("jal_jal", e_jal());
    cyc("jal_aluwb", e_aluwb());

    // fetch ready on the 4th wait cycle: no timeout
    opcode = 7'b0110011; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("to_late_fetch_wait", e_fetch(0));
    mem_ready = 1'b1;
    cyc("to_late_fetch_rdy", e_fetch(1));
    cyc("to_late_decode", e_decode());
    cyc("to_late_exec", e_exec_r());
    cyc("to_late_aluwb", e_aluwb());

    // fetch stuck: timeout trap after 4 wait cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("to_fetch_wait", e_fetch(0));
    cyc("to_trap", e_trap(1));
    mem_ready = 1'b1;
    cyc("to_trap_hold", e_trap(1));
    do_reset();

    // illegal opcode
    opcode = 7'b1110011;
    cyc("ill_fetch", e_fetch(1));
    cyc("ill_decode", e_decode());
    cyc("ill_trap", e_trap(0));
    opcode = 7'b0110011; mem_ready = 1'b0;
    cyc("ill_trap_hold1", e_trap(0));
    mem_ready = 1'b1;
    cyc("ill_trap_hold2", e_trap(0));
    do_reset();

    // async reset mid-instruction (during EXEC_R)
    cyc("mid_fetch", e_fetch(1));
    cyc("mid_decode", e_decode());
    #1;
    check_eq("mid_exec", {15'b0, ctrl}, {15'b0, e_exec_r()});
    do_reset();
    cyc("mid_refetch", e_fetch(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
